// File: rtl/msi_pkg.sv
// -----------------------------------------------------------------------------
// msi_pkg
// Shared MSI coherence definitions used by the requester-side controller and
// the snoop-side FSM: line-state encoding, bus operation codes, snoop message
// codes, the requester FSM state type and a state-normalising helper.
// -----------------------------------------------------------------------------
package msi_pkg;

   // Per-line coherence state. 2'b11 is never produced locally but may arrive
   // from the snoop side; readers map it to Invalid through norm_state().
   typedef enum logic [1:0] {
      ST_INVALID   = 2'b00,
      ST_EXCLUSIVE = 2'b01,
      ST_SHARED    = 2'b10,
      ST_ILLEGAL   = 2'b11
   } line_state_t;

   // Bus operation codes driven on bus_op.
   typedef enum logic [1:0] {
      OP_RM         = 2'b00,
      OP_INVALIDATE = 2'b01,
      OP_WM         = 2'b10,
      OP_WRITE_BACK = 2'b11
   } bus_op_t;

   // Snoop-side response messages.
   typedef enum logic {
      MSG_EMPTY            = 1'b0,
      MSG_WRITE_BACK_BLOCK = 1'b1
   } msg_t;

   // Requester FSM states.
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOOKUP = 3'd1,
      S_WB     = 3'd2,
      S_BUS    = 3'd3,
      S_UPDATE = 3'd4,
      S_RESP   = 3'd5
   } req_fsm_t;

   // Map a raw stored state onto the legal set (illegal reads as Invalid).
   function automatic line_state_t norm_state(input logic [1:0] raw);
      return (raw == ST_ILLEGAL) ? ST_INVALID : line_state_t'(raw);
   endfunction

endpackage

// File: rtl/msi_line_store.sv
// -----------------------------------------------------------------------------
// msi_line_store
// Coherence state and tag storage for a direct-mapped cache.
//   clock, resetn            : clock, asynchronous active-low reset
//   req_we/index/state/tag   : request-side write port (state + tag)
//   snp_we/index/state       : snoop-side write port (state only)
//   collide                  : both ports target the same line this cycle;
//                              the request write wins, the snoop is dropped
//   look_index/state/tag     : lookup read tap (normalised state + tag)
//   disp_index/state         : display read tap (normalised state)
// -----------------------------------------------------------------------------
module msi_line_store
   import msi_pkg::*;
#(
   parameter int LINES = 4,
   parameter int TAG_W = 3,
   parameter int IDX_W = $clog2(LINES)
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              req_we,
   input  logic [IDX_W-1:0]  req_index,
   input  line_state_t       req_state,
   input  logic [TAG_W-1:0]  req_tag,
   input  logic              snp_we,
   input  logic [IDX_W-1:0]  snp_index,
   input  logic [1:0]        snp_state,
   output logic              collide,
   input  logic [IDX_W-1:0]  look_index,
   output line_state_t       look_state,
   output logic [TAG_W-1:0]  look_tag,
   input  logic [IDX_W-1:0]  disp_index,
   output line_state_t       disp_state
);

   logic [1:0]       state_q [LINES];
   logic [TAG_W-1:0] tag_q   [LINES];

   assign collide = req_we & snp_we & (req_index == snp_index);

   // NOTE: these arrays are architecturally visible coherence state and must
   // come out of reset Invalid, so they are reset explicitly rather than left
   // as uninitialised RAM.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < LINES; i++) begin
            state_q[i] <= ST_INVALID;
            tag_q[i]   <= '0;
         end
      end else begin
         if (snp_we && !collide) begin
            state_q[snp_index] <= snp_state;
         end
         if (req_we) begin
            state_q[req_index] <= req_state;
            tag_q[req_index]   <= req_tag;
         end
      end
   end

   assign look_state = norm_state(state_q[look_index]);
   assign look_tag   = tag_q[look_index];
   assign disp_state = norm_state(state_q[disp_index]);

endmodule

// File: rtl/msi_req_ctrl.sv
// -----------------------------------------------------------------------------
// msi_req_ctrl
// Requester-side MSI coherence controller for a small direct-mapped cache.
// Accepts CPU read/write requests, looks up line state/tag, issues bus
// operations (RM, Invalidate, WM, Write_Back) over a req/gnt handshake and
// commits the new line state.
//   clock, resetn                 : clock, asynchronous active-low reset
//   cpu_valid/ready/write/index/tag : CPU request handshake and address
//   resp_valid, resp_hit          : completion pulse, no-bus-traffic flag
//   bus_req/gnt/op/index/tag      : bus operation handshake and payload
//   snp_we/index/state            : state writes from the snoop-side FSM
//   snp_collide                   : snoop write dropped in favour of UPDATE
//   line_state                    : state of the line at cpu_index
// -----------------------------------------------------------------------------
module msi_req_ctrl
   import msi_pkg::*;
#(
   parameter int LINES = 4,
   parameter int TAG_W = 3,
   parameter int IDX_W = $clog2(LINES)
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              cpu_valid,
   output logic              cpu_ready,
   input  logic              cpu_write,
   input  logic [IDX_W-1:0]  cpu_index,
   input  logic [TAG_W-1:0]  cpu_tag,
   output logic              resp_valid,
   output logic              resp_hit,
   output logic              bus_req,
   input  logic              bus_gnt,
   output logic [1:0]        bus_op,
   output logic [IDX_W-1:0]  bus_index,
   output logic [TAG_W-1:0]  bus_tag,
   input  logic              snp_we,
   input  logic [IDX_W-1:0]  snp_index,
   input  logic [1:0]        snp_state,
   output logic              snp_collide,
   output logic [1:0]        line_state
);

   req_fsm_t         fsm_q, fsm_d;
   logic             req_write_q;
   logic [IDX_W-1:0] req_index_q;
   logic [TAG_W-1:0] req_tag_q;
   bus_op_t          op_q, op_d;
   logic [TAG_W-1:0] bus_tag_q, bus_tag_d;
   line_state_t      target_q, target_d;
   logic             hit_path_q, hit_path_d;

   line_state_t      look_state;
   logic [TAG_W-1:0] look_tag;
   line_state_t      disp_state;
   logic             look_hit;
   logic             accept;
   bus_op_t          miss_op;

   msi_line_store #(
      .LINES (LINES),
      .TAG_W (TAG_W),
      .IDX_W (IDX_W)
   ) u_store (
      .clock      (clock),
      .resetn     (resetn),
      .req_we     (fsm_q == S_UPDATE),
      .req_index  (req_index_q),
      .req_state  (target_q),
      .req_tag    (req_tag_q),
      .snp_we     (snp_we),
      .snp_index  (snp_index),
      .snp_state  (snp_state),
      .collide    (snp_collide),
      .look_index (req_index_q),
      .look_state (look_state),
      .look_tag   (look_tag),
      .disp_index (cpu_index),
      .disp_state (disp_state)
   );

   assign accept   = (fsm_q == S_IDLE) & cpu_valid;
   assign look_hit = (look_state != ST_INVALID) & (look_tag == req_tag_q);
   assign miss_op  = req_write_q ? OP_WM : OP_RM;

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) fsm_q <= S_IDLE;
      else         fsm_q <= fsm_d;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         req_write_q <= 1'b0;
         req_index_q <= '0;
         req_tag_q   <= '0;
         op_q        <= OP_RM;
         bus_tag_q   <= '0;
         target_q    <= ST_INVALID;
         hit_path_q  <= 1'b0;
      end else begin
         if (accept) begin
            req_write_q <= cpu_write;
            req_index_q <= cpu_index;
            req_tag_q   <= cpu_tag;
         end
         op_q       <= op_d;
         bus_tag_q  <= bus_tag_d;
         target_q   <= target_d;
         hit_path_q <= hit_path_d;
      end
   end

   // NOTE: every signal driven here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      fsm_d      = fsm_q;
      op_d       = op_q;
      bus_tag_d  = bus_tag_q;
      target_d   = target_q;
      hit_path_d = hit_path_q;
      case (fsm_q)
         S_IDLE: begin
            if (cpu_valid) fsm_d = S_LOOKUP;
         end
         S_LOOKUP: begin
            hit_path_d = 1'b0;
            if (look_hit && (!req_write_q || look_state == ST_EXCLUSIVE)) begin
               fsm_d      = S_RESP;
               hit_path_d = 1'b1;
            end else if (look_hit) begin
               // Write to a Shared copy: only other copies need killing.
               fsm_d     = S_BUS;
               op_d      = OP_INVALIDATE;
               bus_tag_d = req_tag_q;
               target_d  = ST_EXCLUSIVE;
            end else begin
               target_d = req_write_q ? ST_EXCLUSIVE : ST_SHARED;
               if (look_state == ST_EXCLUSIVE) begin
                  // Dirty victim: write it back under its old tag first.
                  fsm_d     = S_WB;
                  op_d      = OP_WRITE_BACK;
                  bus_tag_d = look_tag;
               end else begin
                  fsm_d     = S_BUS;
                  op_d      = miss_op;
                  bus_tag_d = req_tag_q;
               end
            end
         end
         S_WB: begin
            if (bus_gnt) begin
               fsm_d     = S_BUS;
               op_d      = miss_op;
               bus_tag_d = req_tag_q;
            end
         end
         S_BUS: begin
            if (bus_gnt) fsm_d = S_UPDATE;
         end
         S_UPDATE: fsm_d = S_RESP;
         S_RESP:   fsm_d = S_IDLE;
         default:  fsm_d = S_IDLE;
      endcase
   end

   assign cpu_ready  = (fsm_q == S_IDLE);
   assign resp_valid = (fsm_q == S_RESP);
   assign resp_hit   = resp_valid & hit_path_q;
   assign bus_req    = (fsm_q == S_WB) | (fsm_q == S_BUS);
   assign bus_op     = op_q;
   assign bus_index  = req_index_q;
   assign bus_tag    = bus_tag_q;
   assign line_state = disp_state;

endmodule

// File: tb/tb_msi_req_ctrl.sv
// -----------------------------------------------------------------------------
// tb_msi_req_ctrl
// Self-checking bench for msi_req_ctrl (LINES = 4, TAG_W = 3). A behavioural
// model of the cache (state/tag arrays) predicts the bus operation sequence,
// response type and final line state of every request; directed scenarios are
// followed by randomized requests and snoop writes.
// -----------------------------------------------------------------------------
module tb_msi_req_ctrl;

   localparam int LINES = 4;
   localparam int TAG_W = 3;
   localparam int IDX_W = 2;

   logic             clock = 1'b0;
   logic             resetn = 1'b0;
   logic             cpu_valid = 1'b0;
   logic             cpu_ready;
   logic             cpu_write = 1'b0;
   logic [IDX_W-1:0] cpu_index = '0;
   logic [TAG_W-1:0] cpu_tag = '0;
   logic             resp_valid;
   logic             resp_hit;
   logic             bus_req;
   logic             bus_gnt = 1'b0;
   logic [1:0]       bus_op;
   logic [IDX_W-1:0] bus_index;
   logic [TAG_W-1:0] bus_tag;
   logic             snp_we = 1'b0;
   logic [IDX_W-1:0] snp_index = '0;
   logic [1:0]       snp_state = '0;
   logic             snp_collide;
   logic [1:0]       line_state;

   int passed = 0;
   int failed = 0;
   int total  = 0;

   // Reference model of the cache contents (raw state as written).
   logic [1:0]       m_state [LINES];
   logic [TAG_W-1:0] m_tag   [LINES];

   always #5 clock = ~clock;

   msi_req_ctrl #(.LINES(LINES), .TAG_W(TAG_W)) dut (
      .clock       (clock),
      .resetn      (resetn),
      .cpu_valid   (cpu_valid),
      .cpu_ready   (cpu_ready),
      .cpu_write   (cpu_write),
      .cpu_index   (cpu_index),
      .cpu_tag     (cpu_tag),
      .resp_valid  (resp_valid),
      .resp_hit    (resp_hit),
      .bus_req     (bus_req),
      .bus_gnt     (bus_gnt),
      .bus_op      (bus_op),
      .bus_index   (bus_index),
      .bus_tag     (bus_tag),
      .snp_we      (snp_we),
      .snp_index   (snp_index),
      .snp_state   (snp_state),
      .snp_collide (snp_collide),
      .line_state  (line_state)
   );

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      @(negedge clock);
   endtask

   // Illegal encoding 11 reads back as Invalid.
   function automatic logic [1:0] legal(input logic [1:0] s);
      return (s == 2'b11) ? 2'b00 : s;
   endfunction

   task automatic clear_model();
      for (int i = 0; i < LINES; i++) begin
         m_state[i] = 2'b00;
         m_tag[i]   = '0;
      end
   endtask

   // One CPU request. gwait = idle cycles before each grant. Optionally a
   // snoop write is driven during the UPDATE cycle.
   task automatic do_req(input logic wr, input logic [IDX_W-1:0] idx,
                         input logic [TAG_W-1:0] tg, input int gwait,
                         input logic snp_en, input logic [IDX_W-1:0] s_idx,
                         input logic [1:0] s_st, input string nm);
      logic [1:0]       ops  [$];
      logic [TAG_W-1:0] tags [$];
      logic [1:0]       cur;
      logic [1:0]       tgt;
      logic             hit;
      int               cnt;
      cur = legal(m_state[idx]);
      hit = (cur != 2'b00) && (m_tag[idx] == tg);
      tgt = cur;
      if (hit && wr && cur == 2'b10) begin
         ops.push_back(2'b01); tags.push_back(tg); tgt = 2'b01;
      end else if (!hit) begin
         if (cur == 2'b01) begin
            ops.push_back(2'b11); tags.push_back(m_tag[idx]);
         end
         ops.push_back(wr ? 2'b10 : 2'b00); tags.push_back(tg);
         tgt = wr ? 2'b01 : 2'b10;
      end

      cnt = 0;
      while (!cpu_ready && cnt < 20) begin
         step();
         cnt++;
      end
      check({nm, "/ready"}, 32'(cpu_ready), 32'd1);
      cpu_valid = 1'b1; cpu_write = wr; cpu_index = idx; cpu_tag = tg;
      step();
      cpu_valid = 1'b0;
      check({nm, "/lookup_ready"}, 32'(cpu_ready), 32'd0);
      check({nm, "/lookup_busreq"}, 32'(bus_req), 32'd0);
      check({nm, "/lookup_resp"}, 32'(resp_valid), 32'd0);
      step();

      if (ops.size() == 0) begin
         check({nm, "/hit_resp"}, 32'(resp_valid), 32'd1);
         check({nm, "/hit_flag"}, 32'(resp_hit), 32'd1);
         check({nm, "/hit_nobus"}, 32'(bus_req), 32'd0);
      end else begin
         for (int k = 0; k < ops.size(); k++) begin
            for (int w = 0; w < gwait; w++) begin
               check({nm, "/wait_req"}, 32'(bus_req), 32'd1);
               check({nm, "/wait_op"}, 32'(bus_op), 32'(ops[k]));
               step();
            end
            check({nm, "/bus_req"}, 32'(bus_req), 32'd1);
            check({nm, "/bus_op"}, 32'(bus_op), 32'(ops[k]));
            check({nm, "/bus_index"}, 32'(bus_index), 32'(idx));
            check({nm, "/bus_tag"}, 32'(bus_tag), 32'(tags[k]));
            check({nm, "/bus_noresp"}, 32'(resp_valid), 32'd0);
            bus_gnt = 1'b1;
            step();
            bus_gnt = 1'b0;
         end
         check({nm, "/upd_busreq"}, 32'(bus_req), 32'd0);
         check({nm, "/upd_resp"}, 32'(resp_valid), 32'd0);
         if (snp_en) begin
            snp_we = 1'b1; snp_index = s_idx; snp_state = s_st;
         end
         #1;
         check({nm, "/collide"}, 32'(snp_collide), 32'(snp_en && (s_idx == idx)));
         step();
         snp_we = 1'b0;
         if (snp_en && s_idx != idx) m_state[s_idx] = s_st;
         check({nm, "/miss_resp"}, 32'(resp_valid), 32'd1);
         check({nm, "/miss_flag"}, 32'(resp_hit), 32'd0);
         check({nm, "/collide_gone"}, 32'(snp_collide), 32'd0);
      end
      m_state[idx] = tgt;
      m_tag[idx]   = tg;
      step();
      check({nm, "/idle_ready"}, 32'(cpu_ready), 32'd1);
      check({nm, "/idle_resp"}, 32'(resp_valid), 32'd0);
      #1;
      check({nm, "/line_state"}, 32'(line_state), 32'(legal(m_state[idx])));
      if (snp_en) begin
         cpu_index = s_idx;
         #1;
         check({nm, "/snp_line_state"}, 32'(line_state), 32'(legal(m_state[s_idx])));
      end
   endtask

   // Snoop write while the controller is idle.
   task automatic idle_snoop(input logic [IDX_W-1:0] idx, input logic [1:0] st);
      snp_we = 1'b1; snp_index = idx; snp_state = st; cpu_index = idx;
      #1;
      check("idle_snoop/collide", 32'(snp_collide), 32'd0);
      step();
      snp_we = 1'b0;
      m_state[idx] = st;
      check("idle_snoop/line_state", 32'(line_state), 32'(legal(st)));
   endtask

   initial begin
      logic             r_wr;
      logic [IDX_W-1:0] r_idx;
      logic [TAG_W-1:0] r_tag;
      logic [IDX_W-1:0] r_sidx;
      logic [1:0]       r_sst;

      clear_model();
      @(negedge clock);
      @(negedge clock);
      // Reset state while resetn is held low.
      check("reset/cpu_ready", 32'(cpu_ready), 32'd1);
      check("reset/resp_valid", 32'(resp_valid), 32'd0);
      check("reset/resp_hit", 32'(resp_hit), 32'd0);
      check("reset/bus_req", 32'(bus_req), 32'd0);
      check("reset/bus_op", 32'(bus_op), 32'd0);
      check("reset/bus_index", 32'(bus_index), 32'd0);
      check("reset/bus_tag", 32'(bus_tag), 32'd0);
      check("reset/snp_collide", 32'(snp_collide), 32'd0);
      check("reset/line_state", 32'(line_state), 32'd0);
      resetn = 1'b1;
      step();

      // Directed scenarios.
      do_req(1'b0, 2'd1, 3'd5, 3, 1'b0, 2'd0, 2'd0, "rd_miss");
      do_req(1'b0, 2'd1, 3'd5, 0, 1'b0, 2'd0, 2'd0, "rd_hit");
      do_req(1'b1, 2'd1, 3'd5, 1, 1'b0, 2'd0, 2'd0, "wr_inval");
      do_req(1'b1, 2'd1, 3'd5, 0, 1'b0, 2'd0, 2'd0, "wr_hit");
      do_req(1'b1, 2'd1, 3'd2, 2, 1'b0, 2'd0, 2'd0, "wr_wb");
      do_req(1'b0, 2'd1, 3'd6, 0, 1'b1, 2'd1, 2'd0, "collide_same");
      idle_snoop(2'd2, 2'b10);
      do_req(1'b1, 2'd1, 3'd6, 1, 1'b1, 2'd2, 2'd0, "snoop_other");
      idle_snoop(2'd3, 2'b11);

      // Randomized requests and snoop writes.
      for (int n = 0; n < 40; n++) begin
         r_wr   = 1'($urandom_range(0, 1));
         r_idx  = 2'($urandom_range(0, 3));
         r_tag  = 3'($urandom_range(0, 2));
         r_sidx = 2'($urandom_range(0, 3));
         r_sst  = 2'($urandom_range(0, 3));
         do_req(r_wr, r_idx, r_tag, int'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), r_sidx, r_sst, "rand");
         if ($urandom_range(0, 2) == 0) begin
            idle_snoop(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
         end
      end

      // Reset while waiting for a bus grant.
      cpu_valid = 1'b1; cpu_write = 1'b0; cpu_index = 2'd3; cpu_tag = 3'd7;
      step();
      cpu_valid = 1'b0;
      step();
      check("rst_mid/bus_req_before", 32'(bus_req), 32'd1);
      step();
      resetn = 1'b0;
      #1;
      check("rst_mid/bus_req", 32'(bus_req), 32'd0);
      check("rst_mid/cpu_ready", 32'(cpu_ready), 32'd1);
      check("rst_mid/resp_valid", 32'(resp_valid), 32'd0);
      step();
      resetn = 1'b1;
      clear_model();
      step();
      for (int i = 0; i < LINES; i++) begin
         cpu_index = IDX_W'(i);
         #1;
         check("rst_mid/line_invalid", 32'(line_state), 32'(legal(m_state[i])));
      end
      do_req(1'b0, 2'd3, 3'd7, 0, 1'b0, 2'd0, 2'd0, "post_rst");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
